// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480 timing constants, axis-total helper and phase enum.
// Latency: none (declarations only).
// Backpressure: none.
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } phase_t;

    function automatic int axis_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: one timing axis -- position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Latency: pos/phase update on the advancing edge; phase_nxt and wrap are combinational.
// Backpressure: state holds whenever advance is low.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY   = DEF_H_DISPLAY,
    parameter int FRONT_LEN = DEF_H_FRONT,
    parameter int SYNC_LEN  = DEF_H_SYNC,
    parameter int BACK_LEN  = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [POS_W-1:0] pos,
    output phase_t           phase,
    output phase_t           phase_nxt,
    output logic             wrap
);

    localparam int TOTAL = axis_total(DISPLAY, FRONT_LEN, SYNC_LEN, BACK_LEN);

    // Last position of each phase; the FSM leaves a phase on the edge that steps past it.
    localparam logic [POS_W-1:0] LAST      = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] ACT_END   = POS_W'(DISPLAY - 1);
    localparam logic [POS_W-1:0] FRONT_END = POS_W'(DISPLAY + FRONT_LEN - 1);
    localparam logic [POS_W-1:0] SYNC_END  = POS_W'(DISPLAY + FRONT_LEN + SYNC_LEN - 1);

    assign wrap = (pos == LAST);

    always_comb begin
        phase_nxt = phase;
        if (advance) begin
            case (phase)
                ACTIVE:  if (pos == ACT_END)   phase_nxt = FRONT;
                FRONT:   if (pos == FRONT_END) phase_nxt = SYNC;
                SYNC:    if (pos == SYNC_END)  phase_nxt = BACK;
                BACK:    if (wrap)             phase_nxt = ACTIVE;
                default:                       phase_nxt = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos   <= '0;
            phase <= ACTIVE;
        end else if (advance) begin
            pos   <= wrap ? '0 : pos + POS_W'(1);
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_timer.sv
// Purpose: VGA raster timer -- hpos/vpos, registered syncs, display enable, line/frame ticks, frame count.
// Latency: syncs registered from next phase, so zero skew against hpos/vpos.
// Backpressure: pix_en low freezes all state and outputs.
module vga_sync_timer
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [9:0] frame
);

    localparam logic SYNC_ON = (SYNC_POL != 0);

    phase_t h_phase;
    phase_t h_phase_nxt;
    phase_t v_phase;
    phase_t v_phase_nxt;
    logic   h_wrap;
    logic   v_wrap;
    logic   v_advance;

    assign v_advance = pix_en & h_wrap;

    vga_axis_counter #(
        .DISPLAY   (H_DISPLAY),
        .FRONT_LEN (H_FRONT),
        .SYNC_LEN  (H_SYNC),
        .BACK_LEN  (H_BACK)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .advance   (pix_en),
        .pos       (hpos),
        .phase     (h_phase),
        .phase_nxt (h_phase_nxt),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .DISPLAY   (V_DISPLAY),
        .FRONT_LEN (V_FRONT),
        .SYNC_LEN  (V_SYNC),
        .BACK_LEN  (V_BACK)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .advance   (v_advance),
        .pos       (vpos),
        .phase     (v_phase),
        .phase_nxt (v_phase_nxt),
        .wrap      (v_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= ~SYNC_ON;
            vsync <= ~SYNC_ON;
            frame <= '0;
        end else begin
            hsync <= (h_phase_nxt == SYNC) ? SYNC_ON : ~SYNC_ON;
            vsync <= (v_phase_nxt == SYNC) ? SYNC_ON : ~SYNC_ON;
            if (v_advance && v_wrap) begin
                frame <= frame + 10'd1;
            end
        end
    end

    // Decoded from the registered phases so it lines up with hpos/vpos; blanked during reset.
    assign display_on = (h_phase == ACTIVE) && (v_phase == ACTIVE) && !reset;
    assign line_tick  = h_wrap;
    assign frame_tick = h_wrap & v_wrap;

endmodule

// File: tb/tb_vga_sync_timer.sv
// Bench: default 640x480 timer plus two tiny-raster timers (active-low and active-high sync).
module tb_vga_sync_timer;

    localparam int DHD = 640, DHF = 16, DHS = 96, DHB = 48, DHT = DHD + DHF + DHS + DHB;
    localparam int DVD = 480, DVF = 10, DVS = 2,  DVB = 33, DVT = DVD + DVF + DVS + DVB;
    localparam int SHD = 4,   SHF = 1,  SHS = 2,  SHB = 1,  SHT = SHD + SHF + SHS + SHB;
    localparam int SVD = 3,   SVF = 1,  SVS = 2,  SVB = 1,  SVT = SVD + SVF + SVS + SVB;
    localparam int SFRAME = SHT * SVT;

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic [9:0] frame;
        logic       hsync;
        logic       vsync;
        logic       disp;
        logic       lt;
        logic       ft;
    } out_t;

    typedef struct packed {
        out_t d;
        out_t s;
        out_t p;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b1;

    logic       d_hs, d_vs, d_de, d_lt, d_ft;
    logic [9:0] d_hpos, d_vpos, d_frame;
    logic       s_hs, s_vs, s_de, s_lt, s_ft;
    logic [9:0] s_hpos, s_vpos, s_frame;
    logic       p_hs, p_vs, p_de, p_lt, p_ft;
    logic [9:0] p_hpos, p_vpos, p_frame;

    int n_chk = 0;
    int n_pass = 0;
    int dh = 0, dv = 0, df = 0;
    int sh = 0, sv = 0, sf = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vga_sync_timer dd (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
        .hpos(d_hpos), .vpos(d_vpos), .line_tick(d_lt), .frame_tick(d_ft), .frame(d_frame)
    );

    vga_sync_timer #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(0)
    ) ds (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
        .hpos(s_hpos), .vpos(s_vpos), .line_tick(s_lt), .frame_tick(s_ft), .frame(s_frame)
    );

    vga_sync_timer #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1)
    ) dp (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(p_hs), .vsync(p_vs), .display_on(p_de),
        .hpos(p_hpos), .vpos(p_vpos), .line_tick(p_lt), .frame_tick(p_ft), .frame(p_frame)
    );

    function automatic out_t obs_d();
        return {d_hpos, d_vpos, d_frame, d_hs, d_vs, d_de, d_lt, d_ft};
    endfunction
    function automatic out_t obs_s();
        return {s_hpos, s_vpos, s_frame, s_hs, s_vs, s_de, s_lt, s_ft};
    endfunction
    function automatic out_t obs_p();
        return {p_hpos, p_vpos, p_frame, p_hs, p_vs, p_de, p_lt, p_ft};
    endfunction

    // Reference raster: outputs follow directly from the position and the window bounds.
    function automatic out_t model_out(input int h, input int v, input int f,
                                       input int hd, input int hf, input int hs, input int ht,
                                       input int vd, input int vf, input int vs, input int vt,
                                       input logic pol, input logic rst);
        out_t o;
        o.hpos  = 10'(h);
        o.vpos  = 10'(v);
        o.frame = 10'(f);
        o.hsync = (h >= hd + hf && h < hd + hf + hs) ? pol : ~pol;
        o.vsync = (v >= vd + vf && v < vd + vf + vs) ? pol : ~pol;
        o.disp  = (h < hd) && (v < vd) && !rst;
        o.lt    = (h == ht - 1);
        o.ft    = (h == ht - 1) && (v == vt - 1);
        return o;
    endfunction

    task automatic adv(inout int h, inout int v, inout int f, input int ht, input int vt);
        if (h == ht - 1) begin
            h = 0;
            if (v == vt - 1) begin
                v = 0;
                f = (f + 1) % 1024;
            end else begin
                v = v + 1;
            end
        end else begin
            h = h + 1;
        end
    endtask

    // Drive one clock of stimulus and queue what every DUT must show after that edge.
    task automatic drive(input logic en, input logic rst);
        exp_t e;
        pix_en = en;
        reset  = rst;
        if (rst) begin
            dh = 0; dv = 0; df = 0;
            sh = 0; sv = 0; sf = 0;
        end else if (en) begin
            adv(dh, dv, df, DHT, DVT);
            adv(sh, sv, sf, SHT, SVT);
        end
        e.d = model_out(dh, dv, df, DHD, DHF, DHS, DHT, DVD, DVF, DVS, DVT, 1'b0, rst);
        e.s = model_out(sh, sv, sf, SHD, SHF, SHS, SHT, SVD, SVF, SVS, SVT, 1'b0, rst);
        e.p = model_out(sh, sv, sf, SHD, SHF, SHS, SHT, SVD, SVF, SVS, SVT, 1'b1, rst);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1);
            e = sb.pop_front();
            n_chk++;
            if ({obs_d(), obs_s(), obs_p()} !== e)
                $display("FAIL reset_sb got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
            else n_pass++;
        end
        n_chk++;
        if ({d_hs, d_vs, d_de} !== 3'b110) $display("FAIL reset_sync_de got=%b want=110", {d_hs, d_vs, d_de});
        else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({d_hpos, d_vpos, d_de, s_de, p_de} !== {10'd0, 10'd0, 3'b111})
            $display("FAIL release_idle got=%0d,%0d,%b want=0,0,111", d_hpos, d_vpos, {d_de, s_de, p_de});
        else n_pass++;
        drive(1'b1, 1'b0);
        e = sb.pop_front();
        n_chk++;
        if ({obs_d(), obs_s(), obs_p()} !== e)
            $display("FAIL first_step_sb got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
        else n_pass++;
        n_chk++;
        if (d_hpos !== 10'd1) $display("FAIL first_step_hpos got=%0d want=1", d_hpos);
        else n_pass++;
    endtask

    task automatic test_line();
        exp_t e;
        int lf = 0, hs_low = 0, lt_cnt = 0;
        logic [9:0] lt_pos = '0;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int c = 0; c < DHT; c++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            if (lf < 5) begin
                n_chk++;
                if ({obs_d(), obs_s(), obs_p()} !== e) begin
                    lf++;
                    $display("FAIL line_sb got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
                end else n_pass++;
            end
            if (d_hs === 1'b0) hs_low++;
            if (d_lt === 1'b1) begin
                lt_cnt++;
                lt_pos = d_hpos;
            end
        end
        n_chk++;
        if (hs_low != 96) $display("FAIL hsync_low_count got=%0d want=96", hs_low);
        else n_pass++;
        n_chk++;
        if (lt_cnt != 1 || lt_pos !== 10'd799)
            $display("FAIL line_tick got=%0d@%0d want=1@799", lt_cnt, lt_pos);
        else n_pass++;
        n_chk++;
        if ({d_hpos, d_vpos} !== {10'd0, 10'd1})
            $display("FAIL line_wrap got=%0d,%0d want=0,1", d_hpos, d_vpos);
        else n_pass++;
    endtask

    task automatic test_pix_en();
        exp_t e;
        int lf = 0, wraps = 0, w1 = 0, w2 = 0, moves = 0, moves_off = 0;
        logic [9:0] prev_h;
        logic en;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        prev_h = d_hpos;
        for (int c = 0; c < 2 * 2 * DHT; c++) begin
            en = ((c % 2) == 0);
            drive(en, 1'b0);
            e = sb.pop_front();
            if (lf < 5) begin
                n_chk++;
                if ({obs_d(), obs_s(), obs_p()} !== e) begin
                    lf++;
                    $display("FAIL pix_en_sb got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
                end else n_pass++;
            end
            if (d_hpos !== prev_h) begin
                moves++;
                if (!en) moves_off++;
            end
            if (prev_h === 10'd799 && d_hpos === 10'd0) begin
                wraps++;
                if (wraps == 1) w1 = c;
                else w2 = c;
            end
            prev_h = d_hpos;
        end
        n_chk++;
        if (moves != 2 * DHT || moves_off != 0)
            $display("FAIL pix_en_moves got=%0d/%0d want=1600/0", moves, moves_off);
        else n_pass++;
        n_chk++;
        if (wraps != 2 || (w2 - w1) != 1600)
            $display("FAIL line_period got=%0d wraps,%0d clks want=2,1600", wraps, w2 - w1);
        else n_pass++;
        n_chk++;
        if (d_vpos !== 10'd2) $display("FAIL pix_en_vpos got=%0d want=2", d_vpos);
        else n_pass++;
    endtask

    task automatic test_frame();
        exp_t e;
        int lf = 0, vs_low = 0, de_cnt = 0, ft_cnt = 0, pvs_hi = 0, phs_hi = 0;
        logic [19:0] ft_pos = '0;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int c = 0; c < SFRAME; c++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            if (lf < 5) begin
                n_chk++;
                if ({obs_d(), obs_s(), obs_p()} !== e) begin
                    lf++;
                    $display("FAIL frame_sb got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
                end else n_pass++;
            end
            if (s_vs === 1'b0) vs_low++;
            if (s_de === 1'b1) de_cnt++;
            if (p_vs === 1'b1) pvs_hi++;
            if (p_hs === 1'b1) phs_hi++;
            if (s_ft === 1'b1) begin
                ft_cnt++;
                ft_pos = {s_hpos, s_vpos};
            end
        end
        n_chk++;
        if (vs_low != SVS * SHT) $display("FAIL vsync_low_count got=%0d want=%0d", vs_low, SVS * SHT);
        else n_pass++;
        n_chk++;
        if (de_cnt != SHD * SVD) $display("FAIL display_count got=%0d want=%0d", de_cnt, SHD * SVD);
        else n_pass++;
        n_chk++;
        if (ft_cnt != 1 || ft_pos !== {10'd7, 10'd6})
            $display("FAIL frame_tick got=%0d@%h want=1@(7,6)", ft_cnt, ft_pos);
        else n_pass++;
        n_chk++;
        if (s_frame !== 10'd1) $display("FAIL frame_count got=%0d want=1", s_frame);
        else n_pass++;
        n_chk++;
        if (pvs_hi != SVS * SHT || phs_hi != SHS * SVT)
            $display("FAIL pos_pol_sync got=%0d,%0d want=%0d,%0d", pvs_hi, phs_hi, SVS * SHT, SHS * SVT);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sync();
        exp_t e;
        int lf = 0;
        for (int c = 0; c < 200; c++) begin
            if (sh == 5 && sv == 5) break;
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            if (lf < 5) begin
                n_chk++;
                if ({obs_d(), obs_s(), obs_p()} !== e) begin
                    lf++;
                    $display("FAIL mid_sync_sb got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
                end else n_pass++;
            end
        end
        n_chk++;
        if ({s_hpos, s_vpos, s_hs, s_vs} !== {10'd5, 10'd5, 2'b00})
            $display("FAIL mid_sync_reach got=%0d,%0d,%b want=5,5,00", s_hpos, s_vpos, {s_hs, s_vs});
        else n_pass++;
        drive(1'b1, 1'b1);
        e = sb.pop_front();
        n_chk++;
        if ({obs_d(), obs_s(), obs_p()} !== e)
            $display("FAIL abort_sb got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
        else n_pass++;
        n_chk++;
        if ({s_hpos, s_vpos, s_hs, s_vs, s_de, p_hs, p_vs} !== {10'd0, 10'd0, 5'b11000})
            $display("FAIL abort_state got=%0d,%0d,%b want=0,0,11000", s_hpos, s_vpos,
                     {s_hs, s_vs, s_de, p_hs, p_vs});
        else n_pass++;
        drive(1'b0, 1'b1);
        e = sb.pop_front();
        n_chk++;
        if ({obs_d(), obs_s(), obs_p()} !== e || s_frame !== 10'd0 || d_de !== 1'b0)
            $display("FAIL reset_hold got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
        else n_pass++;
    endtask

    task automatic test_frame_wrap();
        exp_t e;
        int lf = 0, ft_total = 0, ft_last = 0;
        bit saw_max = 0;
        for (int c = 0; c < 1024 * SFRAME; c++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            if (lf < 5) begin
                n_chk++;
                if ({obs_d(), obs_s(), obs_p()} !== e) begin
                    lf++;
                    $display("FAIL wrap_sb got=%h want=%h", {obs_d(), obs_s(), obs_p()}, e);
                end else n_pass++;
            end
            if (s_frame === 10'd1023) saw_max = 1;
            if (s_ft === 1'b1) begin
                ft_total++;
                if (s_frame === 10'd1023) ft_last++;
            end
        end
        n_chk++;
        if (!saw_max || ft_last != 1) $display("FAIL last_frame got=%0d,%0d want=1,1", saw_max, ft_last);
        else n_pass++;
        n_chk++;
        if (ft_total != 1024) $display("FAIL frame_tick_total got=%0d want=1024", ft_total);
        else n_pass++;
        n_chk++;
        if ({s_frame, s_hpos, s_vpos} !== 30'd0)
            $display("FAIL frame_wrap got=%0d,%0d,%0d want=0,0,0", s_frame, s_hpos, s_vpos);
        else n_pass++;
        n_chk++;
        if (sb.size() != 0) $display("FAIL sb_leftover got=%0d want=0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_line();
        test_pix_en();
        test_frame();
        test_reset_mid_sync();
        test_frame_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_sync_timer.md
VGA_SYNC_TIMER -- requirements
Module: vga_sync_timer

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_DISPLAY, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, asserted level of hsync and vsync (0 = active-low).
REQ-006 clk  input  1  pixel-domain clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pix_en  input  1  pixel advance enable; counters step only when high.
REQ-009 hsync  output  1  horizontal sync at SYNC_POL level during H sync phase.
REQ-010 vsync  output  1  vertical sync at SYNC_POL level during V sync phase.
REQ-011 display_on  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-012 hpos  output  10  current pixel column, 0..H_TOTAL-1.
REQ-013 vpos  output  10  current line, 0..V_TOTAL-1.
REQ-014 line_tick  output  1  one-pixel pulse on the last pixel of every line.
REQ-015 frame_tick  output  1  one-pixel pulse on the last pixel of every frame.
REQ-016 frame  output  10  frame counter, replacing vsync-edge-clocked counters downstream.

Function
REQ-017 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
REQ-018 On each clk edge with pix_en=1, hpos increments by 1; at H_TOTAL-1 it wraps to 0.
REQ-019 vpos increments only on the same edge hpos wraps; at V_TOTAL-1 it wraps to 0.
REQ-020 With pix_en=0, all registered state and all outputs hold unchanged.
REQ-021 Horizontal phase FSM states H_ACTIVE, H_FRONT, H_SYNC, H_BACK; transitions at hpos = H_DISPLAY, +H_FRONT, +H_SYNC, and at wrap back to H_ACTIVE.
REQ-022 Vertical phase FSM states V_ACTIVE, V_FRONT, V_SYNC, V_BACK; transitions identical in structure, advanced only on line wrap.
REQ-023 hsync, vsync, display_on SHALL be registered, computed from next-state, zero-cycle skew vs hpos/vpos (default: hsync asserted for hpos 656..751, vsync for vpos 490..491).
REQ-024 line_tick = 1 exactly while hpos = H_TOTAL-1, combinational from registered hpos, independent of pix_en.
REQ-025 frame_tick = 1 exactly while hpos = H_TOTAL-1 and vpos = V_TOTAL-1.
REQ-026 frame increments by 1 on the edge where vpos wraps; 1023 wraps to 0 modulo 2^10.
REQ-027 display_on SHALL be forced 0 while reset is high.

Reset
REQ-028 reset high at a clk edge: hpos=0, vpos=0, frame=0, FSMs to H_ACTIVE/V_ACTIVE, hsync=vsync=~SYNC_POL; regardless of pix_en.
REQ-029 Reset mid-line or mid-sync SHALL abort immediately; no partial sync pulse persists past the reset edge.
REQ-030 First edge after reset release with pix_en=1 yields hpos=1; cycle in between presents hpos=0, vpos=0, display_on=1.

Structure
REQ-031 Package vga_timing_pkg SHALL hold default 640x480 timing constants, H_TOTAL/V_TOTAL derivation, and the phase enum (ACTIVE, FRONT, SYNC, BACK).
REQ-032 One sub-module vga_axis_counter SHALL implement counter + phase FSM (inputs advance, outputs pos, phase, wrap), instantiated twice (horizontal, vertical).

Verification
REQ-033 Reset, pix_en=1 for 800 cycles -> hsync low exactly hpos 656..751 (96 cycles), line_tick once at hpos 799, vpos 0->1 after it.
REQ-034 Run 420000 cycles (one frame) -> vsync low only vpos 490..491, frame_tick once at (799,524), frame 0->1, display_on count = 307200.
REQ-035 pix_en toggled 1/0 alternately for two lines -> hpos advances every other cycle, all outputs stable during pix_en=0 cycles, line period 1600 clks.
REQ-036 Assert reset at hpos 700, vpos 491 (both syncs active) -> next cycle hpos=0, vpos=0, hsync=vsync=1, display_on=0 while reset held.
REQ-037 Force frame=1023 via 1024 frames (or backdoor), complete frame -> frame=0, frame_tick single pulse.
REQ-038 SYNC_POL=1 build, one frame -> hsync/vsync high only in sync windows, timing identical to REQ-034.
